divider_ctrl: RTL and testbench

// Run-time controller for the toggle-type signal divider datapath. It owns the

---
 rtl/div_pkg.sv | 13 +
 rtl/divider_core.sv | 67 ++++++
 rtl/divider_ctrl.sv | 132 +++++++++++++
 tb/tb_divider_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the toggle-type signal divider.
package div_pkg;

   localparam int DIV_CNT_W = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      SWITCH = 2'd2,
      STOP   = 2'd3
   } div_state_t;

endpackage

// File: rtl/divider_core.sv
// Half-period counter, coefficient register and toggle flop of the divider.
// The controller decides when to count, when to force low and when to load.
module divider_core
   import div_pkg::*;
#(
   parameter int CNT_W        = DIV_CNT_W,
   parameter int DEFAULT_COEF = 4
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             load_coef,
   input  logic [CNT_W-1:0] coef,
   input  logic             run,
   input  logic             force_low,
   output logic             bnd,
   output logic             out,
   output logic             tick
);

   localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
   localparam logic [CNT_W-1:0] RESET_COEF = CNT_W'(DEFAULT_COEF);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] coef_q, coef_d;
   logic             out_q, out_d;
   logic             tick_q, tick_d;

   // coef_q is never zero, so coef_q - 1 cannot wrap
   assign bnd = (cnt_q == coef_q - ONE);

   always_comb begin
      cnt_d  = cnt_q;
      out_d  = out_q;
      coef_d = coef_q;
      if (load_coef) begin
         coef_d = coef;
      end
      if (!run || force_low) begin
         cnt_d = '0;
         out_d = 1'b0;
      end else if (bnd) begin
         cnt_d = '0;
         out_d = ~out_q;
      end else begin
         cnt_d = cnt_q + ONE;
      end
      tick_d = out_d & ~out_q;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_q  <= '0;
         coef_q <= RESET_COEF;
         out_q  <= 1'b0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         coef_q <= coef_d;
         out_q  <= out_d;
         tick_q <= tick_d;
      end
   end

   assign out  = out_q;
   assign tick = tick_q;

endmodule

// File: rtl/divider_ctrl.sv
// Run-time controller for the divider: coefficient handshake and start/stop FSM.
// Coefficient changes and stops only land on a falling edge of out.
module divider_ctrl
   import div_pkg::*;
#(
   parameter int CNT_W        = DIV_CNT_W,
   parameter int DEFAULT_COEF = 4
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             cfg_valid,
   input  logic [CNT_W-1:0] cfg_coef,
   output logic             cfg_ready,
   output logic             cfg_err,
   input  logic             en,
   output logic             busy,
   output logic             out,
   output logic             tick
);

   div_state_t       state_q, state_d;
   logic             pend_q, pend_d;
   logic [CNT_W-1:0] pend_coef_q, pend_coef_d;
   logic             cfg_err_q, cfg_err_d;

   logic             accept;
   logic             coef_ok;
   logic             load_coef;
   logic [CNT_W-1:0] core_coef;
   logic             run;
   logic             force_low;
   logic             bnd;

   assign cfg_ready = ((state_q == IDLE) || (state_q == RUN)) && !pend_q;
   assign accept    = cfg_valid && cfg_ready;
   assign coef_ok   = accept && (cfg_coef != '0);
   assign busy      = (state_q != IDLE);
   assign cfg_err   = cfg_err_q;

   always_comb begin
      state_d     = state_q;
      pend_d      = pend_q;
      pend_coef_d = pend_coef_q;
      cfg_err_d   = accept && (cfg_coef == '0);
      load_coef   = 1'b0;
      core_coef   = pend_coef_q;
      run         = 1'b0;
      force_low   = 1'b0;

      case (state_q)
         IDLE: begin
            if (coef_ok) begin
               load_coef = 1'b1;
               core_coef = cfg_coef;
            end
            if (en) begin
               state_d = RUN;
            end
         end
         RUN: begin
            run = 1'b1;
            if (coef_ok) begin
               pend_d      = 1'b1;
               pend_coef_d = cfg_coef;
            end
            if (!en) begin
               state_d = STOP;
            end else if (coef_ok) begin
               state_d = SWITCH;
            end
         end
         SWITCH: begin
            // A falling boundary that coincides with en=0 is handled by STOP
            run = 1'b1;
            if (!en) begin
               state_d = STOP;
            end else if (bnd && out) begin
               force_low = 1'b1;
               load_coef = 1'b1;
               pend_d    = 1'b0;
               state_d   = RUN;
            end
         end
         STOP: begin
            run = 1'b1;
            if (!out) begin
               force_low = 1'b1;
               load_coef = pend_q;
               pend_d    = 1'b0;
               state_d   = IDLE;
            end else if (bnd) begin
               load_coef = pend_q;
               pend_d    = 1'b0;
               state_d   = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= IDLE;
         pend_q      <= 1'b0;
         pend_coef_q <= '0;
         cfg_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         pend_q      <= pend_d;
         pend_coef_q <= pend_coef_d;
         cfg_err_q   <= cfg_err_d;
      end
   end

   divider_core #(
      .CNT_W        (CNT_W),
      .DEFAULT_COEF (DEFAULT_COEF)
   ) u_core (
      .clk       (clk),
      .resetn    (resetn),
      .load_coef (load_coef),
      .coef      (core_coef),
      .run       (run),
      .force_low (force_low),
      .bnd       (bnd),
      .out       (out),
      .tick      (tick)
   );

endmodule

// File: tb/tb_divider_ctrl.sv
// Self-checking bench for divider_ctrl: expected tick spacings are derived from
// the coefficient arithmetic (first rise = coef, period = 2*coef, switch = old + new).
module tb_divider_ctrl;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         resetn;
   logic         cfg_valid;
   logic [W-1:0] cfg_coef;
   logic         cfg_ready;
   logic         cfg_err;
   logic         en;
   logic         busy;
   logic         out;
   logic         tick;

   int checks = 0;
   int errors = 0;
   int cur_coef;

   always #5 clk = ~clk;

   divider_ctrl #(
      .CNT_W        (W),
      .DEFAULT_COEF (4)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .cfg_valid (cfg_valid),
      .cfg_coef  (cfg_coef),
      .cfg_ready (cfg_ready),
      .cfg_err   (cfg_err),
      .en        (en),
      .busy      (busy),
      .out       (out),
      .tick      (tick)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Returns the number of edges until tick is seen, or -1 on timeout
   task automatic wait_tick(input int budget, output int n);
      n = -1;
      for (int i = 1; i <= budget; i++) begin
         step();
         if (tick === 1'b1) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      resetn    = 1'b0;
      en        = 1'b0;
      cfg_valid = 1'b0;
      cfg_coef  = '0;
      #12;
      checks++;
      if (out !== 1'b0) begin errors++; $display("[TB] FAIL reset_out: got %b expected 0", out); end
      checks++;
      if (tick !== 1'b0) begin errors++; $display("[TB] FAIL reset_tick: got %b expected 0", tick); end
      checks++;
      if (cfg_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_cfg_err: got %b expected 0", cfg_err); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
      checks++;
      if (cfg_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_cfg_ready: got %b expected 1", cfg_ready); end
      @(negedge clk);
      resetn = 1'b1;
      step();
      cur_coef = 4;
   endtask

   task automatic test_first_period();
      int n;
      en = 1'b1;
      wait_tick(100, n);
      checks++;
      if (n != cur_coef + 1) begin errors++; $display("[TB] FAIL first_rise: got %0d expected %0d", n, cur_coef + 1); end
      checks++;
      if (out !== 1'b1 || busy !== 1'b1) begin errors++; $display("[TB] FAIL run_levels: got out=%b busy=%b expected 1 1", out, busy); end
      step();
      checks++;
      if (tick !== 1'b0) begin errors++; $display("[TB] FAIL tick_width: got %b expected 0", tick); end
      wait_tick(100, n);
      checks++;
      if (n != 2 * cur_coef - 1) begin errors++; $display("[TB] FAIL period_a: got %0d expected %0d", n, 2 * cur_coef - 1); end
      wait_tick(100, n);
      checks++;
      if (n != 2 * cur_coef) begin errors++; $display("[TB] FAIL period_b: got %0d expected %0d", n, 2 * cur_coef); end
   endtask

   // Called right after a tick in RUN: new coefficient lands after the old high half
   task automatic test_switch(input int c, input string tag);
      int n;
      checks++;
      if (cfg_ready !== 1'b1) begin errors++; $display("[TB] FAIL %s_ready_before: got %b expected 1", tag, cfg_ready); end
      cfg_valid = 1'b1;
      cfg_coef  = W'(c);
      step();
      cfg_valid = 1'b0;
      checks++;
      if (cfg_ready !== 1'b0) begin errors++; $display("[TB] FAIL %s_ready_pending: got %b expected 0", tag, cfg_ready); end
      wait_tick(100, n);
      checks++;
      if (n != cur_coef + c - 1) begin errors++; $display("[TB] FAIL %s_switch_gap: got %0d expected %0d", tag, n, cur_coef + c - 1); end
      cur_coef = c;
      checks++;
      if (cfg_ready !== 1'b1) begin errors++; $display("[TB] FAIL %s_ready_after: got %b expected 1", tag, cfg_ready); end
      wait_tick(100, n);
      checks++;
      if (n != 2 * c) begin errors++; $display("[TB] FAIL %s_new_period: got %0d expected %0d", tag, n, 2 * c); end
   endtask

   task automatic test_zero_coef_run();
      int n;
      cfg_valid = 1'b1;
      cfg_coef  = '0;
      step();
      cfg_valid = 1'b0;
      checks++;
      if (cfg_err !== 1'b1) begin errors++; $display("[TB] FAIL zero_run_err: got %b expected 1", cfg_err); end
      checks++;
      if (cfg_ready !== 1'b1) begin errors++; $display("[TB] FAIL zero_run_ready: got %b expected 1", cfg_ready); end
      step();
      checks++;
      if (cfg_err !== 1'b0) begin errors++; $display("[TB] FAIL zero_run_err_pulse: got %b expected 0", cfg_err); end
      wait_tick(100, n);
      checks++;
      if (n != 2 * cur_coef - 2) begin errors++; $display("[TB] FAIL zero_run_gap: got %0d expected %0d", n, 2 * cur_coef - 2); end
      wait_tick(100, n);
      checks++;
      if (n != 2 * cur_coef) begin errors++; $display("[TB] FAIL zero_run_period: got %0d expected %0d", n, 2 * cur_coef); end
   endtask

   task automatic test_stop_high();
      en = 1'b0;
      repeat (cur_coef - 1) step();
      checks++;
      if (out !== 1'b1 || busy !== 1'b1) begin errors++; $display("[TB] FAIL stop_high_hold: got out=%b busy=%b expected 1 1", out, busy); end
      step();
      checks++;
      if (out !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL stop_high_done: got out=%b busy=%b expected 0 0", out, busy); end
   endtask

   task automatic test_zero_coef_idle();
      int n;
      cfg_valid = 1'b1;
      cfg_coef  = '0;
      step();
      cfg_valid = 1'b0;
      checks++;
      if (cfg_err !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL zero_idle_err: got err=%b busy=%b expected 1 0", cfg_err, busy); end
      step();
      checks++;
      if (cfg_err !== 1'b0) begin errors++; $display("[TB] FAIL zero_idle_err_pulse: got %b expected 0", cfg_err); end
      en = 1'b1;
      wait_tick(100, n);
      checks++;
      if (n != cur_coef + 1) begin errors++; $display("[TB] FAIL zero_idle_restart: got %0d expected %0d", n, cur_coef + 1); end
   endtask

   task automatic test_stop_low();
      repeat (cur_coef) step();
      checks++;
      if (out !== 1'b0) begin errors++; $display("[TB] FAIL stop_low_pre: got %b expected 0", out); end
      en = 1'b0;
      step();
      checks++;
      if (busy !== 1'b1) begin errors++; $display("[TB] FAIL stop_low_busy: got %b expected 1", busy); end
      step();
      checks++;
      if (busy !== 1'b0 || out !== 1'b0) begin errors++; $display("[TB] FAIL stop_low_idle: got busy=%b out=%b expected 0 0", busy, out); end
   endtask

   task automatic test_accept_with_stop(input int c);
      int n;
      en = 1'b1;
      wait_tick(100, n);
      checks++;
      if (n != cur_coef + 1) begin errors++; $display("[TB] FAIL aws_restart: got %0d expected %0d", n, cur_coef + 1); end
      cfg_valid = 1'b1;
      cfg_coef  = W'(c);
      en        = 1'b0;
      step();
      cfg_valid = 1'b0;
      checks++;
      if (cfg_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL aws_pending: got ready=%b busy=%b expected 0 1", cfg_ready, busy); end
      repeat (cur_coef - 2) step();
      checks++;
      if (out !== 1'b1) begin errors++; $display("[TB] FAIL aws_high: got %b expected 1", out); end
      step();
      checks++;
      if (out !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL aws_stopped: got out=%b busy=%b expected 0 0", out, busy); end
      cur_coef = c;
      en = 1'b1;
      wait_tick(100, n);
      checks++;
      if (n != c + 1) begin errors++; $display("[TB] FAIL aws_first_rise: got %0d expected %0d", n, c + 1); end
      wait_tick(100, n);
      checks++;
      if (n != 2 * c) begin errors++; $display("[TB] FAIL aws_period: got %0d expected %0d", n, 2 * c); end
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 4; k++) begin
         test_switch(int'($urandom_range(2, 9)), "b2b");
      end
   endtask

   task automatic test_async_reset();
      int n;
      step();
      checks++;
      if (out !== 1'b1) begin errors++; $display("[TB] FAIL areset_pre: got %b expected 1", out); end
      #2;
      resetn = 1'b0;
      #1;
      checks++;
      if (out !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL areset_async: got out=%b busy=%b expected 0 0", out, busy); end
      checks++;
      if (tick !== 1'b0 || cfg_ready !== 1'b1) begin errors++; $display("[TB] FAIL areset_hs: got tick=%b ready=%b expected 0 1", tick, cfg_ready); end
      en = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      step();
      cur_coef = 4;
      en = 1'b1;
      wait_tick(100, n);
      checks++;
      if (n != 5) begin errors++; $display("[TB] FAIL areset_first_rise: got %0d expected 5", n); end
      wait_tick(100, n);
      checks++;
      if (n != 8) begin errors++; $display("[TB] FAIL areset_period: got %0d expected 8", n); end
   endtask

   initial begin
      test_reset();
      test_first_period();
      test_switch(int'($urandom_range(2, 6)), "sw");
      test_zero_coef_run();
      test_stop_high();
      test_zero_coef_idle();
      test_stop_low();
      test_accept_with_stop(int'($urandom_range(2, 8)));
      test_back_to_back();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
